// File: rtl/l1_mem_arbiter.sv
// Shares one main-memory port between the L1 I-cache refill path and the D-cache refill/writeback path.
// Line bursts of BURST_LEN words; L1_ARB_ROUND_ROBIN_EN alternates grants on contention (fixed D>I otherwise).
module l1_mem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int BW = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN * 4 - 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t            state;
  logic [BW-1:0]     beat;
  logic [ADDR_W-1:0] base;
  logic              we;
  logic              pick_d;
  logic              last_beat;
  logic              gnt_i;
  logic              gnt_d;

`ifdef L1_ARB_ROUND_ROBIN_EN
  logic last_grant;  // 1 = D completed last, 0 = I

  always_comb begin
    pick_d = d_req && (!i_req || !last_grant);
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  assign last_beat = (beat == BW'(BURST_LEN - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      beat  <= '0;
      base  <= '0;
      we    <= 1'b0;
`ifdef L1_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (pick_d) begin
            state <= GNT_D;
            base  <= d_addr & LINE_MASK;
            we    <= d_we;
          end else if (i_req) begin
            state <= GNT_I;
            base  <= i_addr & LINE_MASK;
            we    <= 1'b0;
          end
        end
        default: begin
          // A stalled beat holds everything; the counter wraps to 0 on the final beat.
          if (mem_ready) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              state <= IDLE;
`ifdef L1_ARB_ROUND_ROBIN_EN
              last_grant <= (state == GNT_D);
`endif
            end
          end
        end
      endcase
    end
  end

  assign gnt_i = (state == GNT_I);
  assign gnt_d = (state == GNT_D);
  assign busy  = gnt_i | gnt_d;

  assign mem_req   = busy;
  assign mem_we    = gnt_d & we;
  assign mem_addr  = busy ? base + ADDR_W'({beat, 2'b00}) : '0;
  assign mem_wdata = mem_we ? d_wdata : '0;

  assign i_rvalid = gnt_i & mem_ready;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign i_done   = i_rvalid & last_beat;

  assign d_rvalid = gnt_d & ~we & mem_ready;
  assign d_wready = gnt_d & we & mem_ready;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign d_done   = gnt_d & mem_ready & last_beat;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter: a scoreboard of expected beats is filled as requests are raised
// and drained by a negedge monitor whenever memory completes a beat.
module tb_l1_mem_arbiter;
  localparam int BL = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_rvalid, i_done, d_wready, d_rvalid, d_done, mem_req, mem_we, busy;

  l1_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        who;   // 1 = D, 0 = I
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int passed = 0, failed = 0, total = 0;
  int busy_total = 0, beats_seen = 0, dones_seen = 0, wready_seen = 0;
  logic stall_mode = 1'b0;

  function automatic logic [31:0] rd_fn(logic [31:0] a);
    return 32'hA0 + ((a - 32'h100) >> 2);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(logic who, logic we, logic [31:0] base);
    beat_t e;
    for (int k = 0; k < BL; k++) begin
      e.who  = who;
      e.we   = we;
      e.addr = base + 32'(4 * k);
      e.data = we ? (32'hD000_0000 | 32'(k)) : rd_fn(e.addr);
      e.last = (k == BL - 1);
      sb.push_back(e);
    end
  endtask

  // Memory / D-cache model: ready pattern, read data, and the D-cache writeback word pointer
  initial begin
    logic rtog;
    int   wr_base;
    rtog = 1'b1;
    wr_base = 0;
    mem_ready = 1'b1;
    mem_rdata = '0;
    d_wdata = 32'hD000_0000;
    forever begin
      @(posedge clock);
      #1;
      if (stall_mode) begin
        if (mem_req) begin
          mem_ready = rtog;
          rtog = ~rtog;
        end else begin
          mem_ready = 1'b0;
          rtog = 1'b1;
        end
      end else begin
        mem_ready = 1'b1;
        rtog = 1'b1;
      end
      mem_rdata = rd_fn(mem_addr);
      if (!d_req) wr_base = wready_seen;
      d_wdata = 32'hD000_0000 | 32'(wready_seen - wr_base);
    end
  end

  // Monitor: one line per completed beat; stalls must hold address/data and pulse nothing
  always @(negedge clock) begin
    beat_t e;
    if (reset) begin
      if (busy) busy_total++;
      if (mem_req && mem_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_beat", {31'b0, mem_req}, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("beat %s we=%0d addr=0x%08h exp_data=0x%08h last=%0d",
                   e.who ? "D" : "I", e.we, mem_addr, e.data, e.last);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          if (e.we) begin
            chk("mem_wdata", mem_wdata, e.data);
            chk("d_wready", {31'b0, d_wready}, 32'd1);
            chk("d_rvalid_wr", {31'b0, d_rvalid}, 32'd0);
          end else if (e.who) begin
            chk("d_rvalid", {31'b0, d_rvalid}, 32'd1);
            chk("d_rdata", d_rdata, e.data);
            chk("i_rvalid_unsel", {31'b0, i_rvalid}, 32'd0);
          end else begin
            chk("i_rvalid", {31'b0, i_rvalid}, 32'd1);
            chk("i_rdata", i_rdata, e.data);
            chk("d_rvalid_unsel", {31'b0, d_rvalid}, 32'd0);
            chk("d_rdata_unsel", d_rdata, 32'd0);
          end
          chk(e.who ? "d_done" : "i_done", {31'b0, e.who ? d_done : i_done}, {31'b0, e.last});
          chk("other_done", {31'b0, e.who ? i_done : d_done}, 32'd0);
        end
        beats_seen++;
        if (i_done || d_done) dones_seen++;
        if (d_wready) wready_seen++;
      end else if (mem_req) begin
        if (sb.size() != 0) begin
          chk("stall_addr", mem_addr, sb[0].addr);
          if (sb[0].we) chk("stall_wdata", mem_wdata, sb[0].data);
        end
        chk("stall_pulses", {27'b0, i_rvalid, d_rvalid, d_wready, i_done, d_done}, 32'd0);
      end
    end
  end

  task automatic wait_dones(int n, string tag);
    int tgt = dones_seen + n;
    for (int c = 0; c < 300 && dones_seen < tgt; c++) begin
      @(negedge clock);
      #1;
    end
    if (dones_seen < tgt) chk({"timeout_", tag}, 32'(dones_seen), 32'(tgt));
  endtask

  task automatic wait_beats(int n, string tag);
    int tgt = beats_seen + n;
    for (int c = 0; c < 300 && beats_seen < tgt; c++) begin
      @(negedge clock);
      #1;
    end
    if (beats_seen < tgt) chk({"timeout_", tag}, 32'(beats_seen), 32'(tgt));
  endtask

  initial begin
    int b0;
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_pulses", {27'b0, i_rvalid, d_rvalid, d_wready, i_done, d_done}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // 1: lone I refill from a mid-line address
    b0 = busy_total;
    @(posedge clock); #1;
    i_addr = 32'h104; i_req = 1'b1;
    push_burst(1'b0, 1'b0, 32'h100);
    wait_dones(1, "t1");
    @(posedge clock); #1;
    i_req = 1'b0;
    @(negedge clock); #1;
    chk("t1_busy_cycles", 32'(busy_total - b0), 32'd4);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: simultaneous requests, D first, one idle cycle, then I
    @(posedge clock); #1;
    d_addr = 32'h200; d_we = 1'b0; d_req = 1'b1;
    i_addr = 32'h300; i_req = 1'b1;
    push_burst(1'b1, 1'b0, 32'h200);
    push_burst(1'b0, 1'b0, 32'h300);
    wait_dones(1, "t2d");
    @(posedge clock); #1;
    d_req = 1'b0;
    @(negedge clock); #1;
    chk("t2_idle_gap", {31'b0, busy}, 32'd0);
    wait_dones(1, "t2i");
    @(posedge clock); #1;
    i_req = 1'b0;

    // 3: D writeback with alternating memory stalls
    stall_mode = 1'b1;
    b0 = busy_total;
    @(posedge clock); #1;
    d_addr = 32'h40; d_we = 1'b1; d_req = 1'b1;
    push_burst(1'b1, 1'b1, 32'h40);
    wait_dones(1, "t3");
    @(posedge clock); #1;
    d_req = 1'b0; d_we = 1'b0;
    stall_mode = 1'b0;
    @(negedge clock); #1;
    chk("t3_busy_cycles", 32'(busy_total - b0), 32'd7);

    // 4: reset during beat 2 of an I burst, then a fresh burst at 0x80
    @(posedge clock); #1;
    i_addr = 32'h600; i_req = 1'b1;
    push_burst(1'b0, 1'b0, 32'h600);
    void'(sb.pop_back());
    void'(sb.pop_back());
    wait_beats(2, "t4");
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("t4_mem_req", {31'b0, mem_req}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_mem_addr", mem_addr, 32'd0);
    chk("t4_i_rdata", i_rdata, 32'd0);
    chk("t4_pulses", {27'b0, i_rvalid, d_rvalid, d_wready, i_done, d_done}, 32'd0);
    i_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clock); #1;
    i_addr = 32'h80; i_req = 1'b1;
    push_burst(1'b0, 1'b0, 32'h80);
    wait_dones(1, "t4b");
    @(posedge clock); #1;
    i_req = 1'b0;

    // 5: requester drops i_req after beat 1; burst still completes, then stays idle
    @(posedge clock); #1;
    i_addr = 32'h700; i_req = 1'b1;
    push_burst(1'b0, 1'b0, 32'h700);
    wait_beats(2, "t5");
    @(posedge clock); #1;
    i_req = 1'b0;
    wait_dones(1, "t5");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      chk("t5_stays_idle", {31'b0, busy}, 32'd0);
    end

    // 6: both requests held through four bursts
    @(posedge clock); #1;
    d_addr = 32'h400; d_we = 1'b0; d_req = 1'b1;
    i_addr = 32'h500; i_req = 1'b1;
`ifdef L1_ARB_ROUND_ROBIN_EN
    push_burst(1'b1, 1'b0, 32'h400);
    push_burst(1'b0, 1'b0, 32'h500);
    push_burst(1'b1, 1'b0, 32'h400);
    push_burst(1'b0, 1'b0, 32'h500);
`else
    for (int k = 0; k < 4; k++) push_burst(1'b1, 1'b0, 32'h400);
`endif
    wait_dones(4, "t6");
    @(posedge clock); #1;
    d_req = 1'b0; i_req = 1'b0;
    @(negedge clock); #1;
    chk("t6_idle", {31'b0, busy}, 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
